// File: rtl/div_ctrl.sv
// Fractional clock divider controller: a 32-bit phase accumulator
// run in bursts or continuously, with glitch-free step updates.
//
// Ports:
//   clk, rst        - clock, async active-high reset
//   cfg_valid/step  - step-update request (K, fo = K*fc/2^32)
//   cfg_ready       - step update can be accepted this cycle
//   start/burst_len - run request; burst_len periods, 0 = continuous
//   stop            - stop at the next period boundary
//   clk_out, tick   - divided clock and per-period pulse
//   busy, done      - running flag and end-of-run pulse
module div_ctrl #(
    parameter logic [31:0] RST_STEP = 32'h8000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [31:0]      cfg_step,
    output logic             cfg_ready,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             stop,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      step_q, step_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [32:0]      sum;
    logic             carry;
    logic             idle;
    logic             cfg_acc;

    assign idle      = (state_q == IDLE);
    assign cfg_ready = idle || !pend_q;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign sum       = {1'b0, acc_q} + {1'b0, step_q};
    assign carry     = sum[32];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        step_d    = step_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        rem_d     = rem_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_acc) begin
                    step_d = cfg_step;
                end
                // Acceptance is judged on the step in force now.
                if (start && (step_q != '0)) begin
                    state_d = RUN;
                    acc_d   = '0;
                    rem_d   = burst_len;
                end
            end

            RUN, STOPPING: begin
                acc_d     = sum[31:0];
                clk_out_d = sum[31];
                tick_d    = carry;

                if ((state_q == RUN) && stop) begin
                    state_d = STOPPING;
                end

                // pend_q and cfg_acc are never both set here,
                // since cfg_ready is low while a shadow is pending.
                if (cfg_acc) begin
                    shadow_d = cfg_step;
                    pend_d   = 1'b1;
                end

                if (carry) begin
                    if (pend_q) begin
                        step_d = shadow_q;
                        pend_d = 1'b0;
                    end
                    // Final burst carry beats a coincident stop.
                    if ((state_q == STOPPING) ||
                        (rem_q == CNT_W'(1))) begin
                        state_d = IDLE;
                    end else if (rem_q != '0) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end

                // Leaving the run: park the accumulator and retire
                // any deferred step so IDLE holds no pending update.
                if (state_d == IDLE) begin
                    acc_d     = '0;
                    clk_out_d = 1'b0;
                    rem_d     = '0;
                    pend_d    = 1'b0;
                    if (cfg_acc) begin
                        step_d = cfg_step;
                    end else if (pend_q) begin
                        step_d = shadow_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                acc_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = !idle && (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            step_q    <= RST_STEP;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            rem_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            rem_q     <= rem_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a per-cycle vector table plus
// hand-written sequences for step updates, stops and reset.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_step = '0;
    logic        cfg_ready;
    logic        start = 1'b0;
    logic [15:0] burst_len = '0;
    logic        stop = 1'b0;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_ctrl #(
        .RST_STEP(32'h8000_0000),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_step (cfg_step),
        .cfg_ready(cfg_ready),
        .start    (start),
        .burst_len(burst_len),
        .stop     (stop),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .done     (done)
    );

    // Expected outputs packed as {clk_out, tick, busy, done, cfg_ready}.
    typedef struct {
        logic        cv;
        logic [31:0] cs;
        logic        st;
        logic [15:0] bl;
        logic        sp;
        logic [4:0]  exp;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {clk_out, tick, busy, done, cfg_ready};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got clk/tick/busy/done/rdy=%b want %b",
                     nm, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then check outputs after the edge.
    task automatic cyc(input logic cv, input logic [31:0] cs,
                       input logic st, input logic [15:0] bl,
                       input logic sp, input logic [4:0] exp,
                       input string nm);
        cfg_valid = cv;
        cfg_step  = cs;
        start     = st;
        burst_len = bl;
        stop      = sp;
        @(posedge clk);
        #1;
        check(nm, exp);
    endtask

    task automatic idle(input logic [4:0] exp, input string nm);
        cyc(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, exp, nm);
    endtask

    initial begin
        // Continuous run at the reset step, then stop mid-period.
        tbl[0]  = '{1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 5'b00101};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[2]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b01101};
        tbl[3]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[4]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b01101};
        tbl[5]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 5'b10101};
        tbl[6]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b01011};
        tbl[7]  = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b00001};
        // Quarter step, burst of 3 periods.
        tbl[8]  = '{1'b1, 32'h4000_0000, 1'b0, 16'd0, 1'b0, 5'b00001};
        tbl[9]  = '{1'b0, 32'h0, 1'b1, 16'd3, 1'b0, 5'b00101};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b00101};
        tbl[11] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[12] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[13] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b01101};
        tbl[14] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b00101};
        tbl[15] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[16] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[17] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b01101};
        tbl[18] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b00101};
        tbl[19] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[20] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b10101};
        tbl[21] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b01011};
        tbl[22] = '{1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 5'b00001};

        // Reset state.
        #1;
        check("reset_hold", 5'b00001);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_release", 5'b00001);
        idle(5'b00001, "idle_after_reset");

        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].cv, tbl[i].cs, tbl[i].st, tbl[i].bl,
                tbl[i].sp, tbl[i].exp, $sformatf("tbl[%0d]", i));
        end

        // Step change mid-period: deferred to the period boundary.
        cyc(1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 5'b00101, "upd_start");
        idle(5'b00101, "upd_a1");
        idle(5'b10101, "upd_a2");
        cyc(1'b1, 32'h8000_0000, 1'b0, 16'd0, 1'b0, 5'b10100,
            "upd_pend");
        idle(5'b01101, "upd_wrap");
        idle(5'b10101, "upd_new1");
        idle(5'b01101, "upd_new2");
        idle(5'b10101, "upd_new3");
        idle(5'b01101, "upd_new4");
        cyc(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 5'b10101, "upd_stop");
        idle(5'b01011, "upd_done");
        idle(5'b00001, "upd_idle");

        // Stop coincident with the final burst carry.
        cyc(1'b0, 32'h0, 1'b1, 16'd2, 1'b0, 5'b00101, "last_start");
        idle(5'b10101, "last_c1");
        idle(5'b01101, "last_c2");
        idle(5'b10101, "last_c3");
        cyc(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 5'b01011, "last_stop");
        idle(5'b00001, "last_single_done");
        idle(5'b00001, "last_still_idle");

        // cfg on the carry edge lands in shadow, applies next carry.
        cyc(1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 5'b00101, "co_start");
        idle(5'b10101, "co_c1");
        cyc(1'b1, 32'h4000_0000, 1'b0, 16'd0, 1'b0, 5'b01100,
            "co_cfg_on_carry");
        idle(5'b10100, "co_old_step");
        idle(5'b01101, "co_apply");
        idle(5'b00101, "co_q1");
        idle(5'b10101, "co_q2");
        idle(5'b10101, "co_q3");
        idle(5'b01101, "co_q4");
        cyc(1'b1, 32'h2000_0000, 1'b0, 16'd0, 1'b0, 5'b00100,
            "co_pend_again");

        // Async reset mid-run with a pending shadow.
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 5'b00001);
        @(posedge clk);
        #1;
        check("rst_held", 5'b00001);
        rst = 1'b0;
        idle(5'b00001, "rst_no_done1");
        idle(5'b00001, "rst_no_done2");
        cyc(1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 5'b00101, "rst_start");
        idle(5'b10101, "rst_step_c1");
        idle(5'b01101, "rst_step_c2");
        cyc(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 5'b10101, "rst_stop");
        idle(5'b01011, "rst_done");
        idle(5'b00001, "rst_idle");

        // Zero step blocks start; start with stop enters RUN.
        cyc(1'b1, 32'h0, 1'b0, 16'd0, 1'b0, 5'b00001, "z_cfg0");
        cyc(1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 5'b00001, "z_start_ign");
        idle(5'b00001, "z_still_idle");
        cyc(1'b1, 32'h8000_0000, 1'b0, 16'd0, 1'b0, 5'b00001,
            "z_cfg8");
        cyc(1'b0, 32'h0, 1'b1, 16'd0, 1'b1, 5'b00101,
            "z_start_stop");
        idle(5'b10101, "z_run1");
        idle(5'b01101, "z_run2");
        cyc(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 5'b10101, "z_stop");
        idle(5'b01011, "z_done");
        idle(5'b00001, "z_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
